pkt_reassembler: RTL and testbench

- Receive-side packet framer between the router local output port and the AXI slave RX read path.
- Checks head/body/tail framing per virtual channel against the size field carried in the head flit.
- Buffers accepted flits per VC, marks packet boundaries, and counts complete packets ready for the AXI read side.
- Drops and flags malformed flits.

---
 rtl/pkt_reassembler_if.sv | 29 ++
 rtl/pkt_reassembler.sv | 170 +++++++++++++++++
 tb/tb_pkt_reassembler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_reassembler_if.sv
// Flit ingress and RX read-side bundle for the packet reassembler.
interface pkt_reassembler_if #(
  parameter int NUM_VC      = 3,
  parameter int VC_W        = 2,
  parameter int FLIT_DATA_W = 32
);
  logic                   flit_valid_i;
  logic                   flit_ready_o;
  logic [VC_W-1:0]        flit_vc_i;
  logic [1:0]             flit_type_i;
  logic [FLIT_DATA_W-1:0] flit_data_i;
  logic [VC_W-1:0]        rd_vc_i;
  logic                   rd_req_i;
  logic                   rd_valid_o;
  logic [FLIT_DATA_W-1:0] rd_data_o;
  logic                   rd_last_o;
  logic [NUM_VC-1:0]      pkt_avail_o;
  logic [NUM_VC-1:0]      err_o;
  logic [NUM_VC-1:0]      err_clr_i;

  modport slave (
    input  flit_valid_i, flit_vc_i, flit_type_i, flit_data_i, rd_vc_i, rd_req_i, err_clr_i,
    output flit_ready_o, rd_valid_o, rd_data_o, rd_last_o, pkt_avail_o, err_o
  );
  modport master (
    output flit_valid_i, flit_vc_i, flit_type_i, flit_data_i, rd_vc_i, rd_req_i, err_clr_i,
    input  flit_ready_o, rd_valid_o, rd_data_o, rd_last_o, pkt_avail_o, err_o
  );
endinterface

// File: rtl/pkt_reassembler.sv
// Per-VC head/body/tail framing check, packet FIFO and complete-packet counter.

module pkt_reassembler_vc #(
  parameter int FLIT_DATA_W = 32,
  parameter int PKT_SZ_LSB  = 0,
  parameter int PKT_SZ_W    = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk_axi,
  input  logic                   arst_axi,
  input  logic                   wr_sel,     // valid flit addressed to this VC
  input  logic [1:0]             flit_type,
  input  logic [FLIT_DATA_W-1:0] flit_data,
  input  logic                   rd_sel,     // read request addressed to this VC
  input  logic                   err_clr,
  output logic                   full,
  output logic                   empty,
  output logic [FLIT_DATA_W:0]   head,       // {last, payload}
  output logic                   pkt_avail,
  output logic                   err
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  typedef enum logic {IDLE, RECV} state_t;

  state_t               state, state_nxt;
  logic [PKT_SZ_W-1:0]  rem, rem_nxt, sz;
  logic                 take, wr_en, wr_last, pkt_done, err_set, pop, pop_last;
  logic [AW:0]          wptr, rptr;
  logic [FLIT_DATA_W:0] mem [FIFO_DEPTH];
  logic [CNT_W-1:0]     pkt_cnt;

  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty     = (wptr == rptr);
  assign take      = wr_sel && !full;
  assign sz        = flit_data[PKT_SZ_LSB +: PKT_SZ_W];
  assign head      = mem[rptr[AW-1:0]];
  assign pop       = rd_sel && !empty;
  assign pop_last  = pop && head[FLIT_DATA_W];
  assign pkt_avail = (pkt_cnt != '0);

  // Framing decision for a consumed flit; anything out of sequence is dropped and flagged.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    wr_en     = 1'b0;
    wr_last   = 1'b0;
    pkt_done  = 1'b0;
    err_set   = 1'b0;
    if (take) begin
      case (state)
        IDLE: begin
          if (flit_type == T_HEAD) begin
            wr_en = 1'b1;
            if (sz == '0) begin
              wr_last  = 1'b1;
              pkt_done = 1'b1;
            end else begin
              rem_nxt   = sz;
              state_nxt = RECV;
            end
          end else begin
            err_set = 1'b1;
          end
        end
        RECV: begin
          if (flit_type == T_BODY && rem > PKT_SZ_W'(1)) begin
            wr_en   = 1'b1;
            rem_nxt = rem - PKT_SZ_W'(1);
          end else if (flit_type == T_TAIL && rem == PKT_SZ_W'(1)) begin
            wr_en     = 1'b1;
            wr_last   = 1'b1;
            pkt_done  = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_set = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Framing state, FIFO pointers, packet count and sticky error.
  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      state   <= IDLE;
      rem     <= '0;
      wptr    <= '0;
      rptr    <= '0;
      pkt_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      if (wr_en) wptr <= wptr + (AW+1)'(1);
      if (pop)   rptr <= rptr + (AW+1)'(1);
      case ({pkt_done, pop_last})
        2'b10:   pkt_cnt <= pkt_cnt + CNT_W'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CNT_W'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  // Storage array; contents are don't-care until the write pointer passes them.
  always_ff @(posedge clk_axi) begin
    if (wr_en) mem[wptr[AW-1:0]] <= {wr_last, flit_data};
  end
endmodule

module pkt_reassembler #(
  parameter int NUM_VC      = 3,
  parameter int VC_W        = 2,
  parameter int FLIT_DATA_W = 32,
  parameter int PKT_SZ_LSB  = 0,
  parameter int PKT_SZ_W    = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input logic               clk_axi,
  input logic               arst_axi,
  pkt_reassembler_if.slave  bus
);
  localparam int NUM_SEL = 1 << VC_W;

  logic [NUM_VC-1:0]                  full_v, empty_v;
  logic [NUM_VC-1:0][FLIT_DATA_W:0]   head_v;
  logic [NUM_SEL-1:0]                 full_pad, empty_pad;
  logic [NUM_SEL-1:0][FLIT_DATA_W:0]  head_pad;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    pkt_reassembler_vc #(
      .FLIT_DATA_W(FLIT_DATA_W), .PKT_SZ_LSB(PKT_SZ_LSB),
      .PKT_SZ_W(PKT_SZ_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_vc (
      .clk_axi   (clk_axi),
      .arst_axi  (arst_axi),
      .wr_sel    (bus.flit_valid_i && (bus.flit_vc_i == VC_W'(v))),
      .flit_type (bus.flit_type_i),
      .flit_data (bus.flit_data_i),
      .rd_sel    (bus.rd_req_i && (bus.rd_vc_i == VC_W'(v))),
      .err_clr   (bus.err_clr_i[v]),
      .full      (full_v[v]),
      .empty     (empty_v[v]),
      .head      (head_v[v]),
      .pkt_avail (bus.pkt_avail_o[v]),
      .err       (bus.err_o[v])
    );
  end

  // Pad to the full VC id range: unused ids look never-full (flit sinks) and always-empty.
  always_comb begin
    full_pad  = '0;
    empty_pad = '1;
    head_pad  = '0;
    full_pad[NUM_VC-1:0]  = full_v;
    empty_pad[NUM_VC-1:0] = empty_v;
    head_pad[NUM_VC-1:0]  = head_v;
  end

  assign bus.flit_ready_o = !full_pad[bus.flit_vc_i];
  assign bus.rd_valid_o   = !empty_pad[bus.rd_vc_i];
  assign {bus.rd_last_o, bus.rd_data_o} = head_pad[bus.rd_vc_i];
endmodule

// File: tb/tb_pkt_reassembler.sv
// Scoreboard bench: driver models packet framing per VC and queues expected FIFO
// entries; an independent monitor compares every read-side output against them.
module tb_pkt_reassembler;
  localparam int NUM_VC = 3;
  localparam int VC_W   = 2;
  localparam int DW     = 32;
  localparam int DEPTH  = 8;
  localparam int HEAD = 0, BODY = 1, TAIL = 2, ILL = 3;

  logic clk_axi  = 1'b0;
  logic arst_axi = 1'b0;
  always #5 clk_axi = ~clk_axi;

  pkt_reassembler_if #(.NUM_VC(NUM_VC), .VC_W(VC_W), .FLIT_DATA_W(DW)) bus ();

  pkt_reassembler #(
    .NUM_VC(NUM_VC), .VC_W(VC_W), .FLIT_DATA_W(DW),
    .PKT_SZ_LSB(0), .PKT_SZ_W(8), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_axi  (clk_axi),
    .arst_axi (arst_axi),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: expected FIFO contents {last,data}, flits still owed by the
  // open packet on each VC (0 = between packets), and the sticky error bits.
  logic [DW:0]       exp_q [NUM_VC][$];
  int                need  [NUM_VC];
  logic [NUM_VC-1:0] exp_err;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int n_pkts(int v);
    int n = 0;
    foreach (exp_q[v][i]) if (exp_q[v][i][DW]) n++;
    return n;
  endfunction

  function automatic void model_clear();
    for (int v = 0; v < NUM_VC; v++) begin
      exp_q[v].delete();
      need[v] = 0;
    end
    exp_err = '0;
  endfunction

  // Monitor: outputs sampled late in the cycle, after the driver has settled inputs.
  initial forever begin
    logic [NUM_VC-1:0] ea;
    int  rv;
    bit  ev;
    @(negedge clk_axi);
    #3;
    for (int v = 0; v < NUM_VC; v++) ea[v] = (n_pkts(v) != 0);
    chk("pkt_avail", 64'(bus.pkt_avail_o), 64'(ea));
    chk("err", 64'(bus.err_o), 64'(exp_err));
    rv = int'(bus.rd_vc_i);
    ev = (rv < NUM_VC) && (exp_q[rv].size() > 0);
    chk("rd_valid", 64'(bus.rd_valid_o), 64'(ev));
    if (ev && bus.rd_valid_o) begin
      chk("rd_data", 64'(bus.rd_data_o), 64'(exp_q[rv][0][DW-1:0]));
      chk("rd_last", 64'(bus.rd_last_o), 64'(exp_q[rv][0][DW]));
    end
    if (ev && bus.rd_req_i) void'(exp_q[rv].pop_front());
  end

  // One clock of stimulus; the model is applied just after the edge that commits it.
  task automatic cycle(input bit v, input int vc, input int tp, input logic [DW-1:0] d,
                       input bit rq, input int rvc, input logic [NUM_VC-1:0] clr,
                       output bit acc);
    bit exp_rdy;
    logic [NUM_VC-1:0] set;
    int sz;
    @(negedge clk_axi);
    bus.flit_valid_i = v;
    bus.flit_vc_i    = VC_W'(vc);
    bus.flit_type_i  = 2'(tp);
    bus.flit_data_i  = d;
    bus.rd_req_i     = rq;
    bus.rd_vc_i      = VC_W'(rvc);
    bus.err_clr_i    = clr;
    #2;
    exp_rdy = (vc >= NUM_VC) || (exp_q[vc].size() < DEPTH);
    chk("flit_ready", 64'(bus.flit_ready_o), 64'(exp_rdy));
    acc = v && bus.flit_ready_o;
    @(posedge clk_axi);
    #1;
    set = '0;
    sz  = int'(d[7:0]);
    if (acc && vc < NUM_VC) begin
      if (need[vc] == 0) begin
        if (tp == HEAD) begin
          exp_q[vc].push_back({(sz == 0), d});
          need[vc] = sz;
        end else set[vc] = 1'b1;
      end else if (tp == BODY && need[vc] > 1) begin
        exp_q[vc].push_back({1'b0, d});
        need[vc]--;
      end else if (tp == TAIL && need[vc] == 1) begin
        exp_q[vc].push_back({1'b1, d});
        need[vc] = 0;
      end else set[vc] = 1'b1;
    end
    exp_err = set | (exp_err & ~clr);
  endtask

  task automatic send(input int vc, input int tp, input logic [DW-1:0] d,
                      input bit rq, input int rvc);
    bit acc;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, vc, tp, d, rq, rvc, '0, acc);
      if (acc) return;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout vc=%0d actual=not_accepted expected=accepted", vc);
  endtask

  task automatic idle(input int n, input bit rq, input int rvc);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 0, HEAD, '0, rq, rvc, '0, acc);
  endtask

  task automatic do_reset();
    @(negedge clk_axi);
    arst_axi         = 1'b1;
    bus.flit_valid_i = 1'b0;
    bus.rd_req_i     = 1'b0;
    bus.err_clr_i    = '0;
    model_clear();
    repeat (2) @(negedge clk_axi);
    arst_axi = 1'b0;
  endtask

  function automatic logic [DW-1:0] hd(int sz);
    logic [DW-1:0] d = $urandom;
    d[7:0] = 8'(sz);
    return d;
  endfunction

  initial begin
    bit acc;
    bus.flit_valid_i = 1'b0;
    bus.flit_vc_i    = '0;
    bus.flit_type_i  = '0;
    bus.flit_data_i  = '0;
    bus.rd_req_i     = 1'b0;
    bus.rd_vc_i      = '0;
    bus.err_clr_i    = '0;
    model_clear();
    #1 arst_axi = 1'b1;
    repeat (2) @(negedge clk_axi);
    arst_axi = 1'b0;

    // single-flit packet on VC1, then pop it
    send(1, HEAD, 32'h0000_A500, 1'b0, 1);
    idle(1, 1'b0, 1);
    idle(2, 1'b1, 1);

    // sz=3 on VC0, then four pops
    send(0, HEAD, hd(3), 1'b0, 0);
    send(0, BODY, $urandom, 1'b0, 0);
    send(0, BODY, $urandom, 1'b0, 0);
    send(0, TAIL, $urandom, 1'b0, 0);
    idle(5, 1'b1, 0);

    // interleaved sz=2 packets on VC0 and VC2
    send(0, HEAD, hd(2), 1'b0, 2);
    send(2, HEAD, hd(2), 1'b0, 2);
    send(2, BODY, $urandom, 1'b0, 2);
    send(0, BODY, $urandom, 1'b0, 2);
    send(0, TAIL, $urandom, 1'b0, 2);
    send(2, TAIL, $urandom, 1'b0, 2);
    idle(4, 1'b1, 2);
    idle(4, 1'b1, 0);

    // fill VC1 with a sz=9 packet, VC0 still flows, then drain while finishing
    send(1, HEAD, hd(9), 1'b0, 0);
    for (int i = 0; i < 7; i++) send(1, BODY, $urandom, 1'b0, 0);
    cycle(1'b1, 1, BODY, $urandom, 1'b0, 0, '0, acc);
    cycle(1'b1, 0, HEAD, hd(0), 1'b0, 0, '0, acc);
    send(1, BODY, $urandom, 1'b1, 1);
    send(1, TAIL, $urandom, 1'b1, 1);
    idle(12, 1'b1, 1);
    idle(2, 1'b1, 0);

    // framing errors on VC2, sticky hold, clear, and clear racing a new error
    send(2, BODY, $urandom, 1'b0, 0);
    idle(2, 1'b0, 0);
    send(2, HEAD, hd(1), 1'b0, 0);
    send(2, HEAD, hd(0), 1'b0, 0);
    cycle(1'b0, 0, HEAD, '0, 1'b0, 0, 3'b100, acc);
    idle(1, 1'b0, 0);
    cycle(1'b1, 2, ILL, $urandom, 1'b0, 0, 3'b100, acc);
    idle(1, 1'b0, 0);
    send(2, TAIL, $urandom, 1'b0, 0);
    cycle(1'b0, 0, HEAD, '0, 1'b1, 2, 3'b100, acc);
    idle(2, 1'b1, 2);

    // push and pop of last flits on VC0 in the same cycle with one packet buffered
    send(0, HEAD, hd(0), 1'b0, 0);
    cycle(1'b1, 0, HEAD, hd(0), 1'b1, 0, '0, acc);
    idle(1, 1'b0, 0);
    idle(2, 1'b1, 0);

    // unused VC id sinks flits; reset mid-packet restarts framing from idle
    send(3, BODY, $urandom, 1'b1, 3);
    send(0, HEAD, hd(2), 1'b0, 0);
    send(0, BODY, $urandom, 1'b0, 0);
    send(1, HEAD, hd(0), 1'b0, 0);
    do_reset();
    send(0, HEAD, hd(0), 1'b0, 0);
    idle(2, 1'b1, 0);

    // randomized traffic: light reads (backpressure) then heavy reads
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 1500; n++) begin
        int vc, tp, rvc;
        bit v, rq;
        logic [DW-1:0] d;
        logic [NUM_VC-1:0] clr;
        vc = $urandom_range(0, 3);
        v  = ($urandom_range(0, 3) != 0);
        if (vc >= NUM_VC || $urandom_range(0, 15) == 0) tp = $urandom_range(0, 3);
        else if (need[vc] == 0) tp = HEAD;
        else if (need[vc] > 1) tp = BODY;
        else tp = TAIL;
        d = $urandom;
        if (tp == HEAD)
          d[7:0] = 8'(($urandom_range(0, 7) == 0) ? $urandom_range(8, 12) : $urandom_range(0, 4));
        rq  = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        rvc = $urandom_range(0, 3);
        clr = ($urandom_range(0, 31) == 0) ? NUM_VC'($urandom) : '0;
        cycle(v, vc, tp, d, rq, rvc, clr, acc);
      end
      if (ph == 0) begin
        do_reset();
        idle(2, 1'b1, 1);
      end
    end
    idle(2, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
